ex_wb_collector: RTL and testbench
==================================

EX_WB_COLLECTOR -- requirements
Module: ex_wb_collector

Interface
REQ-001 SHALL have port clk, input, 1, single clock; every flop rises on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port ex_valid_i, input, 1, EX stage result valid.
REQ-004 SHALL have port regfile_alu_we_fw_i, input, 1, EX result requests a register write.
REQ-005 SHALL have port regfile_alu_waddr_fw_i, input, 6, destination register address.
REQ-006 SHALL have port regfile_alu_wdata_fw_i, input, 32, result data.
REQ-007 SHALL have port wb_ready_o, output, 1, collector can accept an EX result; drives EX wb_ready_i.
REQ-008 SHALL have port rf_we_o, output, 1, register-file write request.
REQ-009 SHALL have port rf_waddr_o, output, 6, register-file write address.
REQ-010 SHALL have port rf_wdata_o, output, 32, register-file write data.
REQ-011 SHALL have port rf_ready_i, input, 1, register-file write port free this cycle.
REQ-012 SHALL have port fwd_raddr_i, input, 6, operand address for forwarding lookup.
REQ-013 SHALL have port fwd_hit_o, output, 1, a pending write matches fwd_raddr_i.
REQ-014 SHALL have port fwd_data_o, output, 32, data of the matching pending write.
REQ-015 SHALL have port retired_cnt_o, output, 16, count of accepted EX results.

Function
REQ-016 SHALL accept a result in a cycle iff ex_valid_i=1 and wb_ready_o=1.
REQ-017 SHALL buffer accepted writes in a 2-entry in-order FIFO; only results with regfile_alu_we_fw_i=1 and a nonzero address are pushed.
REQ-018 SHALL accept results with we=0 or waddr=0 without pushing them (x0 writes dropped).
REQ-019 SHALL drive wb_ready_o as a registered function of FIFO occupancy: 1 when occupancy < 2, else 0; there SHALL be no combinational path from any input to wb_ready_o.
REQ-020 SHALL drive rf_we_o=1 whenever the FIFO is non-empty, with rf_waddr_o/rf_wdata_o taken from the head entry.
REQ-021 SHALL pop the head when rf_we_o=1 and rf_ready_i=1; head outputs SHALL stay stable while rf_ready_i=0.
REQ-022 SHALL present an accepted result on rf_we_o no earlier than the cycle after acceptance (minimum latency 1).
REQ-023 SHALL handle simultaneous push and pop with occupancy unchanged and order preserved.
REQ-024 SHALL, when occupancy is 2, hold wb_ready_o=0 until a pop is registered; a pop in cycle N SHALL raise wb_ready_o in cycle N+1.
REQ-025 SHALL increment retired_cnt_o by 1 per accepted result, including dropped ones, and wrap from 0xFFFF to 0x0000.
REQ-026 SHALL ignore ex_valid_i while wb_ready_o=0; nothing is pushed and the counter is unchanged.

Reset
REQ-027 SHALL on rst=1 clear occupancy to 0 and pointers to 0, and force wb_ready_o=1, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd_hit_o=0, fwd_data_o=0, retired_cnt_o=0 from the next edge.
REQ-028 SHALL discard pending entries when rst is asserted mid-operation; no write SHALL issue in the cycle after reset.
REQ-029 SHALL give rst priority over any simultaneous accept or pop.

Configuration
REQ-030 SHALL compile in the forwarding lookup when macro EX_WB_FWD_EN is defined: fwd_hit_o=1 combinationally when any valid entry's address equals fwd_raddr_i; fwd_data_o comes from the youngest match; address 0 never hits.
REQ-031 SHALL, without EX_WB_FWD_EN, tie fwd_hit_o=0 and fwd_data_o=0 and leave fwd_raddr_i unused.

Verification
REQ-032 SHALL cover: reset, then ex_valid_i=1, we=1, waddr=5, wdata=0xDEADBEEF, rf_ready_i=1 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; retired_cnt_o=1.
REQ-033 SHALL cover: rf_ready_i=0 and three back-to-back valid writes to x1, x2, x3 -> first two accepted, wb_ready_o=0 from the third cycle; after rf_ready_i=1, writes issue in order x1, x2, then x3.
REQ-034 SHALL cover: a valid result with waddr=0 and one with we=0 -> both accepted, rf_we_o stays 0, retired_cnt_o increments by 2.
REQ-035 SHALL cover (EX_WB_FWD_EN): pending x7=0x11 then x7=0x22, fwd_raddr_i=7 -> fwd_hit_o=1, fwd_data_o=0x22; fwd_raddr_i=0 -> fwd_hit_o=0.
REQ-036 SHALL cover: counter preloaded to 0xFFFF via 65535 accepts, one more accept -> retired_cnt_o=0x0000.
REQ-037 SHALL cover: two entries pending, rst=1 for one cycle -> rf_we_o=0, wb_ready_o=1, retired_cnt_o=0 next cycle; stale data is never written.

Source files
------------

// File: rtl/ex_wb_collector_if.sv
// EX -> writeback collector bus. This covers the EX result handshake, the
// register-file write port and the operand-forwarding lookup. The collector
// uses the slave modport. The EX stage, register file or bench uses master.
interface ex_wb_collector_if;
    logic        ex_valid_i;
    logic        regfile_alu_we_fw_i;
    logic [5:0]  regfile_alu_waddr_fw_i;
    logic [31:0] regfile_alu_wdata_fw_i;
    logic        wb_ready_o;
    logic        rf_we_o;
    logic [5:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_ready_i;
    logic [5:0]  fwd_raddr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [15:0] retired_cnt_o;

    modport slave (
        input  ex_valid_i, regfile_alu_we_fw_i, regfile_alu_waddr_fw_i,
               regfile_alu_wdata_fw_i, rf_ready_i, fwd_raddr_i,
        output wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               fwd_hit_o, fwd_data_o, retired_cnt_o
    );

    modport master (
        output ex_valid_i, regfile_alu_we_fw_i, regfile_alu_waddr_fw_i,
               regfile_alu_wdata_fw_i, rf_ready_i, fwd_raddr_i,
        input  wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               fwd_hit_o, fwd_data_o, retired_cnt_o
    );
endinterface

// File: rtl/ex_wb_collector.sv
// EX -> writeback collector.
// EX results are buffered in a 2-entry in-order FIFO and drained to the
// register-file write port. Writes to x0 and results with we=0 are accepted
// but dropped. wb_ready_o comes straight from a flop.
// Optional feature: define EX_WB_FWD_EN to build the operand-forwarding
// lookup over pending entries. Without it, fwd_hit_o and fwd_data_o are tied to 0.
module ex_wb_collector (
    input  logic              clk,
    input  logic              rst,
    ex_wb_collector_if.slave  bus
);
    localparam int DEPTH = 2;

    logic [5:0]  addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  occ_reg;
    logic [1:0]  occ_next;
    logic        wb_ready_reg;
    logic [15:0] cnt_reg;

    logic        accept;
    logic        push;
    logic        pop;
    logic        not_empty;

    // Handshake decode and next occupancy. A push and a pop in the same cycle cancel out.
    always_comb begin
        not_empty = (occ_reg != 2'd0);
        accept    = bus.ex_valid_i & wb_ready_reg;
        push      = accept & bus.regfile_alu_we_fw_i & (bus.regfile_alu_waddr_fw_i != 6'd0);
        pop       = not_empty & bus.rf_ready_i;
        occ_next  = occ_reg;
        if (push && !pop) begin
            occ_next = occ_reg + 2'd1;
        end else if (!push && pop) begin
            occ_next = occ_reg - 2'd1;
        end
    end

    // Pointers, occupancy, registered ready and the retired counter. Reset takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            occ_reg      <= 2'd0;
            wb_ready_reg <= 1'b1;
            cnt_reg      <= 16'd0;
        end else begin
            occ_reg      <= occ_next;
            wb_ready_reg <= (occ_next != 2'd2);
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (accept) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    // Entry storage. Stale contents are harmless because the outputs are gated by occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst && push && (wr_ptr_reg == gi[0])) begin
                    addr_mem[gi] <= bus.regfile_alu_waddr_fw_i;
                    data_mem[gi] <= bus.regfile_alu_wdata_fw_i;
                end
            end
        end
    endgenerate

    assign bus.wb_ready_o    = wb_ready_reg;
    assign bus.rf_we_o       = not_empty;
    assign bus.rf_waddr_o    = not_empty ? addr_mem[rd_ptr_reg] : 6'd0;
    assign bus.rf_wdata_o    = not_empty ? data_mem[rd_ptr_reg] : 32'd0;
    assign bus.retired_cnt_o = cnt_reg;

`ifdef EX_WB_FWD_EN
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_match;
    logic             fwd_hit;
    logic [31:0]      fwd_data;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
            // The head is valid at occupancy 1 or more. Both entries are valid at occupancy 2.
            assign entry_valid[gi] = (occ_reg == 2'd2) ||
                                     ((occ_reg == 2'd1) && (rd_ptr_reg == gi[0]));
            assign entry_match[gi] = entry_valid[gi] &&
                                     (addr_mem[gi] == bus.fwd_raddr_i) &&
                                     (bus.fwd_raddr_i != 6'd0);
        end
    endgenerate

    // Look at the older head entry first. A match in the younger entry overrides it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        if (entry_match[rd_ptr_reg]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem[rd_ptr_reg];
        end
        if (entry_match[~rd_ptr_reg]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem[~rd_ptr_reg];
        end
    end

    assign bus.fwd_hit_o  = fwd_hit;
    assign bus.fwd_data_o = fwd_data;
`else
    logic unused_fwd_raddr;
    assign unused_fwd_raddr = ^bus.fwd_raddr_i;
    assign bus.fwd_hit_o    = 1'b0;
    assign bus.fwd_data_o   = 32'd0;
`endif

endmodule

// File: tb/tb_ex_wb_collector.sv
// Bench for ex_wb_collector.
// A table of per-cycle vectors with expected post-edge outputs drives the
// main scenarios. A negedge monitor keeps a queue model of the pending
// writes and the retired count, and checks every issued write against it.
// Hand-written sequences cover forwarding and counter wrap.
module tb_ex_wb_collector;
    logic clk;
    logic rst;
    ex_wb_collector_if bus();

    ex_wb_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mon_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb_q[$];
    logic [15:0] m_cnt;

    // Monitor: compare against the model mid-cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (mon_en != 0) begin
            logic m_ready;
            logic e_hit;
            logic [31:0] e_data;
            m_ready = (sb_q.size() < 2);
            chk("mon_wb_ready", {31'd0, bus.wb_ready_o}, {31'd0, m_ready});
            chk("mon_rf_we", {31'd0, bus.rf_we_o}, {31'd0, (sb_q.size() != 0)});
            chk("mon_cnt", {16'd0, bus.retired_cnt_o}, {16'd0, m_cnt});
            if (sb_q.size() != 0) begin
                chk("mon_waddr", {26'd0, bus.rf_waddr_o}, {26'd0, sb_q[0].a});
                chk("mon_wdata", bus.rf_wdata_o, sb_q[0].d);
            end
            e_hit  = 1'b0;
            e_data = 32'd0;
`ifdef EX_WB_FWD_EN
            foreach (sb_q[i]) begin
                if (sb_q[i].a == bus.fwd_raddr_i && bus.fwd_raddr_i != 6'd0) begin
                    e_hit  = 1'b1;
                    e_data = sb_q[i].d;
                end
            end
`endif
            chk("mon_fwd_hit", {31'd0, bus.fwd_hit_o}, {31'd0, e_hit});
            chk("mon_fwd_data", bus.fwd_data_o, e_data);
            if (rst) begin
                sb_q.delete();
                m_cnt = 16'd0;
            end else begin
                if (sb_q.size() != 0 && bus.rf_ready_i) begin
                    void'(sb_q.pop_front());
                end
                if (m_ready && bus.ex_valid_i) begin
                    m_cnt = m_cnt + 16'd1;
                    if (bus.regfile_alu_we_fw_i && bus.regfile_alu_waddr_fw_i != 6'd0) begin
                        sb_q.push_back({bus.regfile_alu_waddr_fw_i, bus.regfile_alu_wdata_fw_i});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic v, input logic we, input logic [5:0] a,
                         input logic [31:0] d, input logic rdy);
        rst                        = r;
        bus.ex_valid_i             = v;
        bus.regfile_alu_we_fw_i    = we;
        bus.regfile_alu_waddr_fw_i = a;
        bus.regfile_alu_wdata_fw_i = d;
        bus.rf_ready_i             = rdy;
    endtask

    typedef struct {
        logic        rst;
        logic        valid;
        logic        we;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic        rf_ready;
        logic        exp_ready;
        logic        exp_we;
        logic [5:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl[NV];

    initial begin
        // rst valid we waddr wdata rf_rdy | ready we waddr wdata cnt (after the edge)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'd0, 32'h0,         1'b0, 1'b1, 1'b0, 6'd0, 32'h0,         16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF,  1'b1, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF,  16'd1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0,         16'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 6'd1, 32'h11111111,  1'b0, 1'b1, 1'b1, 6'd1, 32'h11111111,  16'd2};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 6'd2, 32'h22222222,  1'b0, 1'b0, 1'b1, 6'd1, 32'h11111111,  16'd3};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 6'd3, 32'h33333333,  1'b0, 1'b0, 1'b1, 6'd1, 32'h11111111,  16'd3};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 6'd3, 32'h33333333,  1'b1, 1'b1, 1'b1, 6'd2, 32'h22222222,  16'd3};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 6'd3, 32'h33333333,  1'b1, 1'b1, 1'b1, 6'd3, 32'h33333333,  16'd4};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0,         16'd4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 6'd0, 32'hAAAA0000,  1'b1, 1'b1, 1'b0, 6'd0, 32'h0,         16'd5};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 6'd9, 32'h99999999,  1'b1, 1'b1, 1'b0, 6'd0, 32'h0,         16'd6};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 6'd4, 32'h44444444,  1'b0, 1'b1, 1'b1, 6'd4, 32'h44444444,  16'd7};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 6'd6, 32'h66666666,  1'b0, 1'b0, 1'b1, 6'd4, 32'h44444444,  16'd8};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 6'd8, 32'h88888888,  1'b1, 1'b1, 1'b0, 6'd0, 32'h0,         16'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0,         16'd0};

        m_cnt           = 16'd0;
        bus.fwd_raddr_i = 6'd0;
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
        tick();
        tick();
        mon_en = 1;

        // Table-driven scenarios: basic write, back-pressure, x0 and we=0 drops, reset mid-flight.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].rf_ready);
            tick();
            chk($sformatf("v%0d_wb_ready", i), {31'd0, bus.wb_ready_o}, {31'd0, tbl[i].exp_ready});
            chk($sformatf("v%0d_rf_we", i), {31'd0, bus.rf_we_o}, {31'd0, tbl[i].exp_we});
            chk($sformatf("v%0d_cnt", i), {16'd0, bus.retired_cnt_o}, {16'd0, tbl[i].exp_cnt});
            if (tbl[i].exp_we || tbl[i].rst) begin
                chk($sformatf("v%0d_waddr", i), {26'd0, bus.rf_waddr_o}, {26'd0, tbl[i].exp_waddr});
                chk($sformatf("v%0d_wdata", i), bus.rf_wdata_o, tbl[i].exp_wdata);
            end
            $display("vec %0d rst=%0d valid=%0d we=%0d waddr=%0d rdy=%0d -> ready=%0d rf_we=%0d cnt=%0d",
                     i, tbl[i].rst, tbl[i].valid, tbl[i].we, tbl[i].waddr, tbl[i].rf_ready,
                     bus.wb_ready_o, bus.rf_we_o, bus.retired_cnt_o);
        end

        // Forwarding: x7=0x11 then x7=0x22 pending, so the youngest entry wins and x0 never hits.
        bus.fwd_raddr_i = 6'd7;
        drive(1'b0, 1'b1, 1'b1, 6'd7, 32'h11, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 6'd7, 32'h22, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
        #1;
`ifdef EX_WB_FWD_EN
        chk("fwd7_hit", {31'd0, bus.fwd_hit_o}, 32'd1);
        chk("fwd7_data", bus.fwd_data_o, 32'h22);
`else
        chk("fwd7_hit", {31'd0, bus.fwd_hit_o}, 32'd0);
        chk("fwd7_data", bus.fwd_data_o, 32'd0);
`endif
        $display("fwd raddr=7 hit=%0d data=%h", bus.fwd_hit_o, bus.fwd_data_o);
        bus.fwd_raddr_i = 6'd0;
        #1;
        chk("fwd0_hit", {31'd0, bus.fwd_hit_o}, 32'd0);
        $display("fwd raddr=0 hit=%0d data=%h", bus.fwd_hit_o, bus.fwd_data_o);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        tick();
        tick();
        tick();
        chk("drain_rf_we", {31'd0, bus.rf_we_o}, 32'd0);

        // Counter wrap: reset, then 65535 dropped accepts reach 0xFFFF, and one more wraps to 0.
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b1);
        for (int n = 0; n < 65535; n++) begin
            tick();
        end
        chk("cnt_ffff", {16'd0, bus.retired_cnt_o}, 32'h0000FFFF);
        $display("wrap pre cnt=%h", bus.retired_cnt_o);
        tick();
        chk("cnt_wrap", {16'd0, bus.retired_cnt_o}, 32'h00000000);
        $display("wrap post cnt=%h", bus.retired_cnt_o);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
